// File: rtl/approx_div_seq_ctrl_if.sv
// Requester-side bundle for approx_div_seq_ctrl: start/operands in, status/results out.
// Latency: wiring only. Backpressure: requester holds start until ready is seen high.
// Widths are fixed by the 16/8 divider array.
interface approx_div_seq_ctrl_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        approx_on;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    modport master (
        output start, dividend, divisor, approx_on,
        input  ready, busy, valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor, approx_on,
        output ready, busy, valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/approx_div_seq_ctrl.sv
// Sequential 16/8 approximate restoring divider: one 9-bit row reused for 8 steps (APPROX_DIV_EN enables approx LSB cells).
// Latency: start accepted at E0, results and a one-cycle valid pulse after E8; one division per 9 cycles.
// Backpressure: ready only in IDLE/DONE; start while busy is ignored.
module approx_div_seq_ctrl #(
    parameter int APPROX_ROWS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    approx_div_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ready_c;
    logic        busy_c;
    logic        accept;

    logic [2:0]  step;
    logic [8:0]  r9;
    logic [6:0]  lo_sr;
    logic [7:0]  dvs_r;
    logic [6:0]  q_sr;
    logic        dz_cap;
    logic        ovf_cap;

    logic [7:0]  quot_r;
    logic [7:0]  rem_r;
    logic        dz_r;
    logic        ovf_r;
    logic        valid_r;

    logic [7:0]  diff;
    logic [7:0]  rout;
    logic        borrow8;
    logic        qs;

`ifdef APPROX_DIV_EN
    localparam int FIRST_APPROX = 8 - APPROX_ROWS;

    logic        aon_r;
    logic [3:0]  depth;
    logic [7:0]  amask;
`endif

    assign accept = ready_c & bus.start;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (step == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef APPROX_DIV_EN
    // Trailing rows get a growing number of approximate LSB cells: 1, 2, ... APPROX_ROWS.
    always_comb begin
        depth = 4'd0;
        if (aon_r && (int'(step) >= FIRST_APPROX)) begin
            depth = 4'(int'(step) - FIRST_APPROX + 1);
        end
        amask = 8'd0;
        for (int i = 0; i < 8; i++) begin
            amask[i] = (i < int'(depth));
        end
    end
`endif

    // ---------------- restoring row ----------------
    always_comb begin : row
        logic bw;
        bw   = 1'b0;
        diff = 8'd0;
        for (int i = 0; i < 8; i++) begin
`ifdef APPROX_DIV_EN
            if (amask[i]) begin
                // Approximate cell passes x through and borrows whenever y is set.
                diff[i] = r9[i];
                bw      = dvs_r[i];
            end else begin
                diff[i] = r9[i] ^ dvs_r[i] ^ bw;
                bw      = (~r9[i] & bw) | (~r9[i] & dvs_r[i]) | (dvs_r[i] & bw);
            end
`else
            diff[i] = r9[i] ^ dvs_r[i] ^ bw;
            bw      = (~r9[i] & bw) | (~r9[i] & dvs_r[i]) | (dvs_r[i] & bw);
`endif
        end
        borrow8 = bw;
    end

    assign qs   = ~borrow8 | r9[8];
    assign rout = qs ? diff : r9[7:0];

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            step    <= 3'd0;
            r9      <= 9'd0;
            lo_sr   <= 7'd0;
            dvs_r   <= 8'd0;
            q_sr    <= 7'd0;
            dz_cap  <= 1'b0;
            ovf_cap <= 1'b0;
            quot_r  <= 8'd0;
            rem_r   <= 8'd0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
`ifdef APPROX_DIV_EN
            aon_r   <= 1'b0;
`endif
        end else begin
            valid_r <= 1'b0;
            if (accept) begin
                step    <= 3'd0;
                r9      <= bus.dividend[15:7];
                lo_sr   <= bus.dividend[6:0];
                dvs_r   <= bus.divisor;
                q_sr    <= 7'd0;
                dz_cap  <= (bus.divisor == 8'd0);
                ovf_cap <= (bus.dividend[15:8] >= bus.divisor);
`ifdef APPROX_DIV_EN
                aon_r   <= bus.approx_on;
`endif
            end else if (state == RUN) begin
                q_sr <= {q_sr[5:0], qs};
                if (step != 3'd7) begin
                    r9    <= {rout, lo_sr[6]};
                    lo_sr <= {lo_sr[5:0], 1'b0};
                    step  <= step + 3'd1;
                end else begin
                    quot_r  <= {q_sr, qs};
                    rem_r   <= rout;
                    dz_r    <= dz_cap;
                    ovf_r   <= ovf_cap;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.ready     = ready_c;
    assign bus.busy      = busy_c;
    assign bus.valid     = valid_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.div_zero  = dz_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_approx_div_seq_ctrl.sv
// Scoreboard bench for approx_div_seq_ctrl: directed divisions, expected results queued at
// acceptance and checked by an independent monitor when valid pulses.
module tb_approx_div_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_div_seq_ctrl_if bus ();

    approx_div_seq_ctrl #(.APPROX_ROWS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        int         at;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 cycle=%0d", cyc);
            end else begin : pop
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_quotient"},  bus.quotient,  e.q);
                chk({e.tag, "_remainder"}, bus.remainder, e.r);
                chk({e.tag, "_div_zero"},  bus.div_zero,  e.dz);
                chk({e.tag, "_ovf"},       bus.ovf,       e.ovf);
                chk({e.tag, "_cycle"},     cyc,           e.at);
            end
        end
    end

    task automatic start_div(input logic [15:0] dvd, input logic [7:0] dvs, input logic aon,
                             output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(negedge clk);
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.start     = 1'b1;
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.approx_on = aon;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acc = cyc;
    endtask

    task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic aon, input logic [7:0] q, input logic [7:0] r,
                           input logic dz, input logic ovf, output int acc);
        exp_t e;
        start_div(dvd, dvs, aon, acc);
        if (acc >= 0) begin
            e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.at = acc + 8; e.tag = tag;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("outstanding_results", sbq.size(), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},     bus.ready,     32'd1);
        chk({tag, "_busy"},      bus.busy,      32'd0);
        chk({tag, "_valid"},     bus.valid,     32'd0);
        chk({tag, "_quotient"},  bus.quotient,  32'd0);
        chk({tag, "_remainder"}, bus.remainder, 32'd0);
        chk({tag, "_div_zero"},  bus.div_zero,  32'd0);
        chk({tag, "_ovf"},       bus.ovf,       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_a;
        int acc_b;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.dividend  = 16'd0;
        bus.divisor   = 8'd0;
        bus.approx_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        run_div("d100_7", 16'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0, acc_a);
        chk("run_busy",  bus.busy,  32'd1);
        chk("run_ready", bus.ready, 32'd0);
        drain();

`ifdef APPROX_DIV_EN
        run_div("d7_1_approx", 16'd7, 8'd1, 1'b1, 8'd3, 8'd7, 1'b0, 1'b0, acc_a);
`else
        run_div("d7_1_approx", 16'd7, 8'd1, 1'b1, 8'd7, 8'd0, 1'b0, 1'b0, acc_a);
`endif
        drain();
        run_div("d7_1_exact", 16'd7, 8'd1, 1'b0, 8'd7, 8'd0, 1'b0, 1'b0, acc_a);
        drain();
        run_div("d1000_8", 16'd1000, 8'd8, 1'b1, 8'd125, 8'd0, 1'b0, 1'b0, acc_a);
        drain();
        run_div("dz_1234", 16'h1234, 8'd0, 1'b0, 8'hFF, 8'h34, 1'b1, 1'b1, acc_a);
        drain();
        run_div("d7f00_80", 16'h7F00, 8'h80, 1'b1, 8'd254, 8'd0, 1'b0, 1'b0, acc_a);
        drain();
        run_div("d200_13", 16'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0, 1'b0, acc_a);
        drain();

        // start pulsed at E3 must be ignored
        run_div("ign_first", 16'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0, acc_a);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor  = 8'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("e3_busy",  bus.busy,  32'd1);
        chk("e3_ready", bus.ready, 32'd0);
        drain();

        // back-to-back: second start lands in the DONE cycle
        run_div("b2b_a", 16'd1000, 8'd8, 1'b0, 8'd125, 8'd0, 1'b0, 1'b0, acc_a);
        run_div("b2b_b", 16'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0, 1'b0, acc_b);
        chk("b2b_gap", acc_b - acc_a, 32'd9);
        drain();

        // reset at E4 aborts with no valid
        start_div(16'h1234, 8'd3, 1'b0, acc_a);
        chk("abort_accepted", (acc_a >= 0), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("abort");
        repeat (12) @(negedge clk);
        run_div("after_abort", 16'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0, acc_a);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
